sw_array_controller: RTL and testbench

//  Sequencer for the linear Smith-Waterman PE systolic array. Loads the query bases into the PEs,

---
 rtl/sw_pkg.sv | 25 ++
 rtl/sw_array_controller.sv | 240 ++++++++++++++++++++++++
 tb/tb_sw_array_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array sequencer: base encodings,
// the biased-zero helper and the controller state encoding.
package sw_pkg;

   // Nucleotide encodings as seen on the query/target streams
   localparam logic [1:0] BASE_A = 2'b00;
   localparam logic [1:0] BASE_G = 2'b01;
   localparam logic [1:0] BASE_T = 2'b10;
   localparam logic [1:0] BASE_C = 2'b11;

   // Controller sequencing states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOADQ  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_RESULT = 3'd4
   } sw_state_e;

   // Biased zero of a score bus of width w: scores are offset by half the range
   function automatic int unsigned zero_of(input int unsigned w);
      return 32'd1 << (w - 32'd1);
   endfunction

endpackage

// File: rtl/sw_array_controller.sv
// Sequencer for the linear Smith-Waterman PE array: loads the query into the
// PEs, streams the target into PE0, waits for the last active PE to report,
// and returns the de-biased high score on a valid/ready port.
module sw_array_controller
   import sw_pkg::*;
#(
   parameter int SCORE_WIDTH = 12,
   parameter int LENGTH      = 128,
   parameter int LOGLENGTH   = 8,
   parameter int TLEN_W      = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [LOGLENGTH-1:0]   q_len,
   input  logic                   q_valid,
   input  logic [1:0]             q_base,
   output logic                   q_ready,
   output logic                   pe_q_we,
   output logic [LOGLENGTH-1:0]   pe_q_addr,
   output logic [1:0]             pe_q_base,
   input  logic                   t_valid,
   input  logic [1:0]             t_base,
   input  logic                   t_last,
   output logic                   t_ready,
   output logic                   arr_en,
   output logic [1:0]             arr_data,
   output logic [SCORE_WIDTH-1:0] arr_M,
   output logic [SCORE_WIDTH-1:0] arr_I,
   output logic [SCORE_WIDTH-1:0] arr_High,
   output logic [LOGLENGTH-1:0]   arr_sel,
   input  logic [SCORE_WIDTH-1:0] arr_high_sel,
   input  logic                   arr_vld_sel,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [SCORE_WIDTH-2:0] res_score,
   output logic                   res_err,
   output logic                   busy
);

   localparam logic [SCORE_WIDTH-1:0] ZERO    = SCORE_WIDTH'(zero_of(SCORE_WIDTH));
   localparam logic [LOGLENGTH:0]     LEN_MAX = (LOGLENGTH+1)'(LENGTH);
   // Last drain cycle before declaring a timeout (LENGTH+8 cycles in DRAIN)
   localparam logic [LOGLENGTH:0]     TO_LAST = (LOGLENGTH+1)'(LENGTH + 7);

   sw_state_e              state_q, state_d;
   logic [LOGLENGTH-1:0]   qlen_q, qlen_d;
   logic [LOGLENGTH-1:0]   q_cnt_q, q_cnt_d;
   logic [TLEN_W-1:0]      t_cnt_q, t_cnt_d;
   logic                   seen_q, seen_d;
   logic                   err_q, err_d;
   logic [LOGLENGTH:0]     to_cnt_q, to_cnt_d;
   logic                   arr_en_q, arr_en_d;
   logic [1:0]             arr_data_q, arr_data_d;
   logic [LOGLENGTH-1:0]   arr_sel_q, arr_sel_d;
   logic                   res_valid_q, res_valid_d;
   logic [SCORE_WIDTH-2:0] res_score_q, res_score_d;
   logic                   res_err_q, res_err_d;
   logic                   busy_q, busy_d;
   logic [SCORE_WIDTH-2:0] score_s;

   // PE0 left-edge boundary is always the biased zero
   assign arr_M    = ZERO;
   assign arr_I    = ZERO;
   assign arr_High = ZERO;

   // Removing the bias: high >= ZERO exactly when its MSB is set, and then
   // high - ZERO is simply the remaining low bits
   assign score_s = arr_high_sel[SCORE_WIDTH-1] ? arr_high_sel[SCORE_WIDTH-2:0]
                                                : {(SCORE_WIDTH-1){1'b0}};

   // Handshake-side outputs decoded from the current state (same-cycle accept)
   always_comb begin
      q_ready   = (state_q == ST_LOADQ)  & ~abort;
      t_ready   = (state_q == ST_STREAM) & ~abort;
      pe_q_we   = q_ready & q_valid;
      pe_q_addr = pe_q_we ? q_cnt_q : {LOGLENGTH{1'b0}};
      pe_q_base = pe_q_we ? q_base  : 2'b00;
   end

   assign arr_en    = arr_en_q;
   assign arr_data  = arr_data_q;
   assign arr_sel   = arr_sel_q;
   assign res_valid = res_valid_q;
   assign res_score = res_score_q;
   assign res_err   = res_err_q;
   assign busy      = busy_q;

   // Next-state, counter and registered-output logic; abort overrides everything
   always_comb begin
      state_d     = state_q;
      qlen_d      = qlen_q;
      q_cnt_d     = q_cnt_q;
      t_cnt_d     = t_cnt_q;
      seen_d      = seen_q;
      err_d       = err_q;
      to_cnt_d    = to_cnt_q;
      arr_en_d    = 1'b0;
      arr_data_d  = 2'b00;
      arr_sel_d   = arr_sel_q;
      res_score_d = res_score_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               qlen_d      = q_len;
               q_cnt_d     = {LOGLENGTH{1'b0}};
               t_cnt_d     = {TLEN_W{1'b0}};
               seen_d      = 1'b0;
               to_cnt_d    = {(LOGLENGTH+1){1'b0}};
               res_score_d = {(SCORE_WIDTH-1){1'b0}};
               if ((q_len == {LOGLENGTH{1'b0}}) || ({1'b0, q_len} > LEN_MAX)) begin
                  err_d     = 1'b1;
                  arr_sel_d = {LOGLENGTH{1'b0}};
                  state_d   = ST_RESULT;
               end else begin
                  err_d     = 1'b0;
                  arr_sel_d = q_len - LOGLENGTH'(1);
                  state_d   = ST_LOADQ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOADQ: begin
            if (q_valid) begin
               q_cnt_d = q_cnt_q + LOGLENGTH'(1);
               if (q_cnt_q == (qlen_q - LOGLENGTH'(1))) begin
                  state_d = ST_STREAM;
               end else begin
                  state_d = ST_LOADQ;
               end
            end else begin
               state_d = ST_LOADQ;
            end
         end
         ST_STREAM: begin
            if (t_valid) begin
               arr_en_d   = 1'b1;
               arr_data_d = t_base;
               seen_d     = 1'b1;
               if (t_cnt_q != {TLEN_W{1'b1}}) begin
                  t_cnt_d = t_cnt_q + TLEN_W'(1);
               end else begin
                  t_cnt_d = t_cnt_q;
               end
               if (t_last) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_STREAM;
               end
            end else if (seen_q) begin
               // The PEs cannot stall, so a gap mid-target corrupts the alignment
               err_d   = 1'b1;
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_DRAIN: begin
            if (arr_vld_sel) begin
               res_score_d = score_s;
               state_d     = ST_RESULT;
            end else if (to_cnt_q == TO_LAST) begin
               err_d       = 1'b1;
               res_score_d = {(SCORE_WIDTH-1){1'b0}};
               state_d     = ST_RESULT;
            end else begin
               to_cnt_d = to_cnt_q + (LOGLENGTH+1)'(1);
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               arr_sel_d   = {LOGLENGTH{1'b0}};
               res_score_d = {(SCORE_WIDTH-1){1'b0}};
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESULT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (abort) begin
         state_d     = ST_IDLE;
         qlen_d      = {LOGLENGTH{1'b0}};
         q_cnt_d     = {LOGLENGTH{1'b0}};
         t_cnt_d     = {TLEN_W{1'b0}};
         seen_d      = 1'b0;
         err_d       = 1'b0;
         to_cnt_d    = {(LOGLENGTH+1){1'b0}};
         arr_en_d    = 1'b0;
         arr_data_d  = 2'b00;
         arr_sel_d   = {LOGLENGTH{1'b0}};
         res_score_d = {(SCORE_WIDTH-1){1'b0}};
      end else begin
         state_d = state_d;
      end
      res_valid_d = (state_d == ST_RESULT);
      res_err_d   = (state_d == ST_RESULT) & err_d;
      busy_d      = (state_d != ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         qlen_q      <= {LOGLENGTH{1'b0}};
         q_cnt_q     <= {LOGLENGTH{1'b0}};
         t_cnt_q     <= {TLEN_W{1'b0}};
         seen_q      <= 1'b0;
         err_q       <= 1'b0;
         to_cnt_q    <= {(LOGLENGTH+1){1'b0}};
         arr_en_q    <= 1'b0;
         arr_data_q  <= 2'b00;
         arr_sel_q   <= {LOGLENGTH{1'b0}};
         res_valid_q <= 1'b0;
         res_score_q <= {(SCORE_WIDTH-1){1'b0}};
         res_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         qlen_q      <= qlen_d;
         q_cnt_q     <= q_cnt_d;
         t_cnt_q     <= t_cnt_d;
         seen_q      <= seen_d;
         err_q       <= err_d;
         to_cnt_q    <= to_cnt_d;
         arr_en_q    <= arr_en_d;
         arr_data_q  <= arr_data_d;
         arr_sel_q   <= arr_sel_d;
         res_valid_q <= res_valid_d;
         res_score_q <= res_score_d;
         res_err_q   <= res_err_d;
         busy_q      <= busy_d;
      end
   end

endmodule

// File: tb/tb_sw_array_controller.sv
// Directed bench for sw_array_controller; the bench plays host, DMA and PE array.
module tb_sw_array_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, abort = 1'b0;
   logic [7:0]  q_len = 8'd0;
   logic        q_valid = 1'b0;
   logic [1:0]  q_base = 2'b00;
   logic        q_ready, pe_q_we;
   logic [7:0]  pe_q_addr;
   logic [1:0]  pe_q_base;
   logic        t_valid = 1'b0, t_last = 1'b0;
   logic [1:0]  t_base = 2'b00;
   logic        t_ready, arr_en;
   logic [1:0]  arr_data;
   logic [11:0] arr_M, arr_I, arr_High;
   logic [7:0]  arr_sel;
   logic [11:0] arr_high_sel = 12'd0;
   logic        arr_vld_sel = 1'b0;
   logic        res_valid, res_err, busy;
   logic        res_ready = 1'b0;
   logic [10:0] res_score;

   int pass_cnt = 0;
   int total_cnt = 0;
   int we_cnt = 0;
   int rv_rise = 0;
   logic rv_prev = 1'b0;

   sw_array_controller dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .q_len(q_len),
      .q_valid(q_valid), .q_base(q_base), .q_ready(q_ready),
      .pe_q_we(pe_q_we), .pe_q_addr(pe_q_addr), .pe_q_base(pe_q_base),
      .t_valid(t_valid), .t_base(t_base), .t_last(t_last), .t_ready(t_ready),
      .arr_en(arr_en), .arr_data(arr_data), .arr_M(arr_M), .arr_I(arr_I),
      .arr_High(arr_High), .arr_sel(arr_sel), .arr_high_sel(arr_high_sel),
      .arr_vld_sel(arr_vld_sel), .res_valid(res_valid), .res_ready(res_ready),
      .res_score(res_score), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Count query writes and rising edges of res_valid, sampled mid-cycle
   always @(negedge clk) begin
      if (pe_q_we) we_cnt = we_cnt + 1;
      if (res_valid && !rv_prev) rv_rise = rv_rise + 1;
      rv_prev = res_valid;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start a job, load len query bases, stream nb target bases ending with t_last
   task automatic go_drain(input int len, input int nb);
      start = 1'b1; q_len = 8'(len); tick(); start = 1'b0;
      for (int i = 0; i < len; i++) begin
         q_valid = 1'b1; q_base = 2'(i); tick();
      end
      q_valid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         t_valid = 1'b1; t_base = 2'(i); t_last = (i == nb - 1); tick();
      end
      t_valid = 1'b0; t_last = 1'b0;
   endtask

   // Report a valid high score from the last PE for one cycle
   task automatic give_high(input logic [11:0] h);
      arr_vld_sel = 1'b1; arr_high_sel = h; tick();
      arr_vld_sel = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d want 0", busy); else pass_cnt++;
      total_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0d want 0", res_valid); else pass_cnt++;
      total_cnt++; if (arr_M !== 12'd2048 || arr_I !== 12'd2048 || arr_High !== 12'd2048)
         $display("FAIL reset_edge_zero: got %0d/%0d/%0d want 2048", arr_M, arr_I, arr_High); else pass_cnt++;
      total_cnt++; if ({q_ready, t_ready, arr_en, pe_q_we, res_err} !== 5'b0)
         $display("FAIL reset_ctl: got %b want 00000", {q_ready, t_ready, arr_en, pe_q_we, res_err}); else pass_cnt++;
      total_cnt++; if (arr_sel !== 8'd0) $display("FAIL reset_arr_sel: got %0d want 0", arr_sel); else pass_cnt++;
      #10 rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [1:0] b [4];
      b[0] = 2'b00; b[1] = 2'b01; b[2] = 2'b10; b[3] = 2'b11;
      we_cnt = 0;
      start = 1'b1; q_len = 8'd4; tick(); start = 1'b0;
      total_cnt++; if (q_ready !== 1'b1 || busy !== 1'b1)
         $display("FAIL loadq_ready: got q_ready=%0d busy=%0d want 1/1", q_ready, busy); else pass_cnt++;
      total_cnt++; if (arr_sel !== 8'd3) $display("FAIL arr_sel: got %0d want 3", arr_sel); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         q_valid = 1'b1; q_base = b[i]; #1;
         total_cnt++; if (pe_q_we !== 1'b1 || pe_q_addr !== 8'(i) || pe_q_base !== b[i])
            $display("FAIL q_write: got we=%0d addr=%0d base=%0d want 1/%0d/%0d", pe_q_we, pe_q_addr, pe_q_base, i, b[i]);
         else pass_cnt++;
         tick();
      end
      q_valid = 1'b0;
      total_cnt++; if (q_ready !== 1'b0 || t_ready !== 1'b1)
         $display("FAIL stream_entry: got q_ready=%0d t_ready=%0d want 0/1", q_ready, t_ready); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         t_valid = 1'b1; t_base = b[i]; t_last = (i == 3); tick();
         total_cnt++; if (arr_en !== 1'b1 || arr_data !== b[i])
            $display("FAIL arr_stream: got en=%0d data=%0d want 1/%0d", arr_en, arr_data, b[i]); else pass_cnt++;
      end
      t_valid = 1'b0; t_last = 1'b0;
      total_cnt++; if (we_cnt !== 4) $display("FAIL q_we_count: got %0d want 4", we_cnt); else pass_cnt++;
      total_cnt++; if (t_ready !== 1'b0) $display("FAIL drain_t_ready: got %0d want 0", t_ready); else pass_cnt++;
      give_high(12'd2056);
      total_cnt++; if (arr_en !== 1'b0) $display("FAIL arr_en_drop: got %0d want 0", arr_en); else pass_cnt++;
      total_cnt++; if (res_valid !== 1'b1 || res_score !== 11'd8 || res_err !== 1'b0)
         $display("FAIL basic_result: got v=%0d score=%0d err=%0d want 1/8/0", res_valid, res_score, res_err); else pass_cnt++;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      total_cnt++; if (res_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL basic_done: got v=%0d busy=%0d want 0/0", res_valid, busy); else pass_cnt++;
   endtask

   task automatic test_underflow();
      int r0;
      r0 = rv_rise;
      start = 1'b1; q_len = 8'd2; tick(); start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         q_valid = 1'b1; q_base = 2'(i); tick();
      end
      q_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         t_valid = 1'b1; t_base = 2'(i + 1); tick();
      end
      t_valid = 1'b0; tick();
      total_cnt++; if (arr_en !== 1'b0 || t_ready !== 1'b0)
         $display("FAIL gap_en: got en=%0d t_ready=%0d want 0/0", arr_en, t_ready); else pass_cnt++;
      give_high(12'd2051);
      total_cnt++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_score !== 11'd3)
         $display("FAIL gap_result: got v=%0d err=%0d score=%0d want 1/1/3", res_valid, res_err, res_score); else pass_cnt++;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      tick(); tick();
      total_cnt++; if (rv_rise - r0 !== 1) $display("FAIL gap_once: got %0d res_valid pulses want 1", rv_rise - r0); else pass_cnt++;
   endtask

   task automatic test_hold();
      go_drain(1, 1);
      give_high(12'd2053);
      for (int i = 0; i < 10; i++) begin
         start = i[0]; q_len = 8'd2; tick();
         total_cnt++; if (res_valid !== 1'b1 || res_score !== 11'd5 || busy !== 1'b1 || res_err !== 1'b0)
            $display("FAIL hold_stable: got v=%0d score=%0d busy=%0d err=%0d want 1/5/1/0", res_valid, res_score, busy, res_err);
         else pass_cnt++;
      end
      start = 1'b0;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      total_cnt++; if (busy !== 1'b0 || res_valid !== 1'b0)
         $display("FAIL hold_release: got busy=%0d v=%0d want 0/0", busy, res_valid); else pass_cnt++;
   endtask

   task automatic test_timeout();
      int n;
      n = 0;
      go_drain(2, 1);
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (res_valid === 1'b1) begin
            n = i;
            break;
         end
      end
      total_cnt++; if (n !== 136) $display("FAIL timeout_cycles: got %0d want 136", n); else pass_cnt++;
      total_cnt++; if (res_err !== 1'b1 || res_score !== 11'd0)
         $display("FAIL timeout_result: got err=%0d score=%0d want 1/0", res_err, res_score); else pass_cnt++;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      start = 1'b1; q_len = 8'd1; tick(); start = 1'b0;
      q_valid = 1'b1; q_base = 2'b10; tick(); q_valid = 1'b0;
      t_valid = 1'b1; t_base = 2'b11; tick(); tick();
      #2 rst = 1'b0; #1;
      total_cnt++; if ({arr_en, busy, t_ready, res_valid} !== 4'b0 || arr_data !== 2'b00 || arr_sel !== 8'd0)
         $display("FAIL async_reset: got en/busy/t_ready/v=%b data=%0d sel=%0d want 0000/0/0",
                  {arr_en, busy, t_ready, res_valid}, arr_data, arr_sel);
      else pass_cnt++;
      t_valid = 1'b0;
      #3 rst = 1'b1;
      tick();
      go_drain(3, 2);
      give_high(12'd2054);
      total_cnt++; if (res_valid !== 1'b1 || res_score !== 11'd6 || res_err !== 1'b0)
         $display("FAIL post_reset_job: got v=%0d score=%0d err=%0d want 1/6/0", res_valid, res_score, res_err); else pass_cnt++;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
   endtask

   task automatic test_abort_and_bad_len();
      go_drain(1, 1);
      give_high(12'd2060);
      abort = 1'b1; res_ready = 1'b1; tick(); abort = 1'b0; res_ready = 1'b0;
      total_cnt++; if (res_valid !== 1'b0 || busy !== 1'b0 || res_score !== 11'd0 || res_err !== 1'b0)
         $display("FAIL abort_result: got v=%0d busy=%0d score=%0d err=%0d want 0/0/0/0", res_valid, busy, res_score, res_err);
      else pass_cnt++;
      start = 1'b1; q_len = 8'd0; tick(); start = 1'b0;
      total_cnt++; if (res_valid !== 1'b1 || res_err !== 1'b1 || res_score !== 11'd0 || q_ready !== 1'b0)
         $display("FAIL qlen0: got v=%0d err=%0d score=%0d q_ready=%0d want 1/1/0/0", res_valid, res_err, res_score, q_ready);
      else pass_cnt++;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      start = 1'b1; q_len = 8'd129; tick(); start = 1'b0;
      total_cnt++; if (res_valid !== 1'b1 || res_err !== 1'b1)
         $display("FAIL qlen129: got v=%0d err=%0d want 1/1", res_valid, res_err); else pass_cnt++;
      res_ready = 1'b1; tick(); res_ready = 1'b0;
      total_cnt++; if (busy !== 1'b0) $display("FAIL bad_len_idle: got busy=%0d want 0", busy); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_hold();
      test_timeout();
      test_async_reset();
      test_abort_and_bad_len();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
